instr_fetch_ctrl: RTL
=====================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch sequencer in front of decode. Issues word-aligned requests to instruction memory
//  and buffers the returned words. Aligns 16/32-bit instructions across word boundaries.
//  Presents one instruction per valid/ready handshake with its PC. Handles redirects
//  (branch/jump/trap) by flushing and dropping stale responses.
// PARAMETERS
//  BOOT_ADDR   32'h0000_0080  reset PC; fetch starts at BOOT_ADDR & ~3
//  FIFO_DEPTH  2              prefetch words (>=2); also the max outstanding requests
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous reset, active-low
//  o_imem_req       out  1   fetch request, held until granted
//  o_imem_addr      out  32  word-aligned fetch address
//  i_imem_gnt       in   1   request accepted this cycle
//  i_imem_rvalid    in   1   in-order response valid (>=1 cycle after gnt)
//  i_imem_rdata     in   32  response word
//  i_redirect       in   1   redirect pulse
//  i_redirect_pc    in   32  target PC (halfword aligned)
//  o_instr_valid    out  1   o_instr/o_pc/o_compr valid
//  i_instr_ready    in   1   consumer accepts
//  o_instr          out  32  32-bit instr, or {16'b0, halfword} if compressed
//  o_pc             out  32  PC of o_instr
//  o_compr          out  1   o_instr is compressed
// BEHAVIOUR
//  Reset values: o_imem_req=0; o_imem_addr=BOOT_ADDR&~3; o_instr_valid=0; o_instr=0;
//   o_pc=BOOT_ADDR; o_compr=0; FIFO empty; counters 0; align state ALIGNED.
//  Fetch FSM F_IDLE/F_REQ. Credit = FIFO_DEPTH - fifo_count - outstanding.
//   F_IDLE->F_REQ when credit>0 (first req the cycle after reset release).
//   In F_REQ, req=1 and addr stays stable until gnt. On gnt: addr+=4, outstanding++.
//   F_REQ->F_IDLE if credit hits 0. rvalid pushes the word and decrements outstanding.
//   A full FIFO on rvalid is impossible by credit; the bench asserts on it.
//  Align FSM ALIGNED(pc[1]=0)/UPPER(pc[1]=1). h = selected halfword of head word.
//   ALIGNED, h[1:0]!=11: compressed, valid if count>=1. Accept: pc+=2, ->UPPER, no pop.
//   ALIGNED, 32-bit: valid if count>=1. Accept: pc+=4, pop.
//   UPPER, compressed: valid if count>=1. Accept: pc+=2, pop, ->ALIGNED.
//   UPPER, 32-bit: {next[15:0],head[31:16]}, valid if count>=2. Accept: pc+=4, pop 1.
//  o_instr/o_pc/o_compr are combinational from FIFO head and pc. They are held stable
//   while valid && !ready.
//  Redirect (same cycle it is seen) has priority over everything else:
//   FIFO flushed; pc=i_redirect_pc; align=UPPER if redirect_pc[1] else ALIGNED.
//   Fetch addr = {redirect_pc[31:2],2'b00}. discard_cnt += outstanding, outstanding=0.
//   An ungranted request is retargeted to the new addr next cycle.
//   A gnt in the redirect cycle counts toward discard.
//   A handshake in the redirect cycle does not advance state; the consumer ignores it.
//  Responses with discard_cnt>0 are dropped (discard_cnt--), including one arriving in
//   the redirect cycle. Credit counts discard_cnt as outstanding.
//  Reset mid-operation clears everything at once. The memory is reset with this block,
//   so pre-reset responses never arrive.
// CONFIGURATION
//  COMPRESSED_EN defined: the alignment above applies.
//  Undefined: align FSM removed; o_compr=0; every head word is one instr (pc+=4, pop).
//   Redirect_pc[1] ignored (pc forced word aligned).
// STRUCTURE
//  Package riviera_fetch_pkg: fetch_state_e, align_state_e, ILEN=32, HLEN=16, is_compr().
//  Sub-module fetch_fifo: sync FIFO with flush and two-entry peek (head, next) plus count.
// TESTING
//  Reset, BOOT_ADDR=0x80, 0-latency gnt, 32-bit words -> req@0x80 on the first cycle;
//   outputs pc 0x80,0x84,0x88.
//  Words 0x0093_4501, 0x4585_0010 -> 0x00004501@0x80 c=1; 0x00100093@0x82 c=0;
//   0x00004585@0x86 c=1.
//  Redirect to 0x102 with 2 outstanding -> both dropped, next req 0x100,
//   first output pc 0x102 from upper half.
//  i_instr_ready=0 for 10 cycles -> outputs stable; req deasserts once FIFO_DEPTH
//   credits are used.
//  gnt delayed 3 cycles -> o_imem_req and o_imem_addr held constant until gnt.
//  COMPRESSED_EN undefined, word 0x0000_4501 -> o_instr=0x00004501, o_compr=0, pc+=4.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
// Holds the fetch/align state encodings, the instruction and halfword widths,
// and the compressed-instruction test used by the alignment logic.
package riviera_fetch_pkg;

  localparam int ILEN = 32;
  localparam int HLEN = 16;

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_state_e;

  typedef enum logic [0:0] {
    ALIGNED = 1'b0,
    UPPER   = 1'b1
  } align_state_e;

  // A halfword starts a 16-bit instruction unless its two low bits are 11.
  function automatic logic is_compr(input logic [HLEN-1:0] half);
    return (half[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle of the fetch sequencer: instruction memory request/response,
// redirect input and the decode-side valid/ready instruction port.
// master = fetch sequencer, slave = memory/decode environment.
interface instr_fetch_ctrl_if;
  import riviera_fetch_pkg::*;

  logic            o_imem_req;
  logic [ILEN-1:0] o_imem_addr;
  logic            i_imem_gnt;
  logic            i_imem_rvalid;
  logic [ILEN-1:0] i_imem_rdata;
  logic            i_redirect;
  logic [ILEN-1:0] i_redirect_pc;
  logic            o_instr_valid;
  logic            i_instr_ready;
  logic [ILEN-1:0] o_instr;
  logic [ILEN-1:0] o_pc;
  logic            o_compr;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  i_redirect, i_redirect_pc,
    output o_instr_valid, o_instr, o_pc, o_compr,
    input  i_instr_ready
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output i_redirect, i_redirect_pc,
    input  o_instr_valid, o_instr, o_pc, o_compr,
    output i_instr_ready
  );

endinterface

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// Prefetch word buffer: synchronous FIFO with flush and a two-entry peek
// (head and the entry behind it) so a 32-bit instruction straddling two
// words can be assembled without popping first.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next pointers/contents: flush wins, otherwise independent push and pop.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (pop_i) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[ptr_inc(rd_q)];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer in front of decode. Issues word-aligned requests under a
// credit scheme (buffer space minus requests in flight), buffers returned
// words, and hands out one instruction per valid/ready handshake.
// Redirects flush the buffer and turn every in-flight response into a drop.
// Build option COMPRESSED_EN: when defined, 16-bit instructions are
// recognised and realigned across word boundaries; otherwise every buffered
// word is one 32-bit instruction and redirect targets are word aligned.
module instr_fetch_ctrl
  import riviera_fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] BOOT_ADDR  = 32'h0000_0080,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_ctrl_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int UW = CW + 2;
  localparam logic [ILEN-1:0] BOOT_WORD = {BOOT_ADDR[ILEN-1:2], 2'b00};

  fetch_state_e    fstate_q, fstate_d;
  logic [ILEN-1:0] addr_q, addr_d;
  logic [CW-1:0]   out_q, out_d;     // granted, response still to come
  logic [CW-1:0]   disc_q, disc_d;   // responses still to come that are stale
  logic [ILEN-1:0] pc_q, pc_d;

  logic            req_s, gnt_acc_s, drop_s, push_s, pop_s, credit_ok_s;
  logic [CW-1:0]   fifo_cnt_s, fifo_cnt_d;
  logic [UW-1:0]   used_d;
  logic [ILEN-1:0] head_s, next_s, instr_s;
  logic            valid_s, compr_s, fire_s;
  logic            unused_bits_s;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ILEN)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.i_redirect),
    .push_i  (push_s),
    .wdata_i (bus.i_imem_rdata),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .next_o  (next_s),
    .count_o (fifo_cnt_s)
  );

  assign req_s     = (fstate_q == F_REQ);
  assign gnt_acc_s = req_s & bus.i_imem_gnt;
  assign drop_s    = bus.i_imem_rvalid & (disc_q != '0);

  // Fetch FSM next state: address advance, in-flight/discard bookkeeping and
  // the credit test that decides whether to keep requesting next cycle.
  always_comb begin
    addr_d   = addr_q;
    out_d    = out_q;
    disc_d   = disc_q;
    push_s   = 1'b0;
    fstate_d = fstate_q;
    if (bus.i_redirect) begin
      // Everything in flight (including a grant or response this cycle) is stale.
      addr_d     = {bus.i_redirect_pc[ILEN-1:2], 2'b00};
      out_d      = '0;
      disc_d     = disc_q + out_q + CW'(gnt_acc_s) - CW'(bus.i_imem_rvalid);
      fifo_cnt_d = '0;
    end else begin
      addr_d     = gnt_acc_s ? (addr_q + 32'd4) : addr_q;
      push_s     = bus.i_imem_rvalid & ~drop_s;
      out_d      = out_q + CW'(gnt_acc_s) - CW'(push_s);
      disc_d     = disc_q - CW'(drop_s);
      fifo_cnt_d = fifo_cnt_s + CW'(push_s) - CW'(pop_s);
    end
    used_d      = UW'(fifo_cnt_d) + UW'(out_d) + UW'(disc_d);
    credit_ok_s = (used_d < UW'(FIFO_DEPTH));
    case (fstate_q)
      F_IDLE:  fstate_d = credit_ok_s ? F_REQ : F_IDLE;
      F_REQ:   fstate_d = credit_ok_s ? F_REQ : F_IDLE;
      default: fstate_d = F_IDLE;
    endcase
  end

  // Fetch FSM and request bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q <= F_IDLE;
      addr_q   <= BOOT_WORD;
      out_q    <= '0;
      disc_q   <= '0;
    end else begin
      fstate_q <= fstate_d;
      addr_q   <= addr_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
    end
  end

`ifdef COMPRESSED_EN
  align_state_e    align_q, align_d;
  logic [HLEN-1:0] half_s;

  // Align FSM: pick the halfword at pc, build the instruction, advance on accept.
  always_comb begin
    pc_d    = pc_q;
    align_d = align_q;
    pop_s   = 1'b0;
    valid_s = 1'b0;
    instr_s = '0;
    half_s  = (align_q == UPPER) ? head_s[31:16] : head_s[15:0];
    compr_s = is_compr(half_s);
    case (align_q)
      ALIGNED: begin
        valid_s = (fifo_cnt_s >= CW'(1));
        instr_s = compr_s ? {16'h0000, half_s} : head_s;
      end
      UPPER: begin
        if (compr_s) begin
          valid_s = (fifo_cnt_s >= CW'(1));
          instr_s = {16'h0000, half_s};
        end else begin
          valid_s = (fifo_cnt_s >= CW'(2));
          instr_s = {next_s[15:0], head_s[31:16]};
        end
      end
      default: begin
        valid_s = 1'b0;
        instr_s = '0;
      end
    endcase
    fire_s = valid_s & bus.i_instr_ready;
    if (bus.i_redirect) begin
      pc_d    = bus.i_redirect_pc;
      align_d = bus.i_redirect_pc[1] ? UPPER : ALIGNED;
    end else if (fire_s) begin
      case (align_q)
        ALIGNED: begin
          if (compr_s) begin
            pc_d    = pc_q + 32'd2;
            align_d = UPPER;
          end else begin
            pc_d  = pc_q + 32'd4;
            pop_s = 1'b1;
          end
        end
        UPPER: begin
          pop_s = 1'b1;
          if (compr_s) begin
            pc_d    = pc_q + 32'd2;
            align_d = ALIGNED;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        default: begin
          pc_d    = pc_q;
          align_d = ALIGNED;
        end
      endcase
    end else begin
      pc_d    = pc_q;
      align_d = align_q;
    end
  end

  // Align state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_q <= ALIGNED;
    end else begin
      align_q <= align_d;
    end
  end

  // Only the low half of the second word is ever spliced into an instruction.
  assign unused_bits_s = ^next_s[31:16];
`else
  // Word-per-instruction issue: head word is the instruction, advance by 4.
  always_comb begin
    pc_d    = pc_q;
    pop_s   = 1'b0;
    valid_s = (fifo_cnt_s >= CW'(1));
    instr_s = head_s;
    compr_s = 1'b0;
    fire_s  = valid_s & bus.i_instr_ready;
    if (bus.i_redirect) begin
      pc_d = {bus.i_redirect_pc[ILEN-1:2], 2'b00};
    end else if (fire_s) begin
      pc_d  = pc_q + 32'd4;
      pop_s = 1'b1;
    end else begin
      pc_d = pc_q;
    end
  end

  // No straddling in this build: the peeked word and halfword offset go unused.
  assign unused_bits_s = ^{next_s, bus.i_redirect_pc[1:0]};
`endif

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= BOOT_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.o_imem_req    = req_s;
  assign bus.o_imem_addr   = addr_q;
  assign bus.o_instr_valid = valid_s;
  assign bus.o_instr       = valid_s ? instr_s : '0;
  assign bus.o_pc          = pc_q;
  assign bus.o_compr       = valid_s & compr_s;

endmodule
